// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine with one micro-rotation per clock and valid/ready on both sides.
// Modes: circular rotation/vectoring, linear rotation (MAC) and hyperbolic rotation (exp).
module cordic_iter_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    ext_reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              sel,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic [1:0]              sel_out,
    output logic                    sat
);

    localparam int DW = WIDTH + GUARD;
    localparam int IW = 5;
    localparam logic [IW-1:0] LAST_LIN = IW'(ITER - 1);
    localparam logic [IW-1:0] LAST_HYP = IW'(ITER);
    localparam logic signed [DW-1:0] SAT_HI = {{(GUARD + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_LO = {{(GUARD + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) in Q2.30; beyond i=10 the angle equals 2^-i to within one Q2.30 LSB
    function automatic logic signed [31:0] circ_raw(input logic [IW-1:0] i);
        case (i)
            5'd0:    circ_raw = 32'sd843314857;
            5'd1:    circ_raw = 32'sd497837829;
            5'd2:    circ_raw = 32'sd263043837;
            5'd3:    circ_raw = 32'sd133525159;
            5'd4:    circ_raw = 32'sd67021687;
            5'd5:    circ_raw = 32'sd33543516;
            5'd6:    circ_raw = 32'sd16775851;
            5'd7:    circ_raw = 32'sd8388437;
            5'd8:    circ_raw = 32'sd4194283;
            5'd9:    circ_raw = 32'sd2097149;
            default: circ_raw = 32'sh4000_0000 >>> i;
        endcase
    endfunction

    // atanh(2^-i) in Q2.30; index 0 is never used in hyperbolic mode
    function automatic logic signed [31:0] hyp_raw(input logic [IW-1:0] i);
        case (i)
            5'd1:    hyp_raw = 32'sd589812981;
            5'd2:    hyp_raw = 32'sd274247419;
            5'd3:    hyp_raw = 32'sd134923407;
            5'd4:    hyp_raw = 32'sd67196450;
            5'd5:    hyp_raw = 32'sd33565361;
            5'd6:    hyp_raw = 32'sd16778581;
            5'd7:    hyp_raw = 32'sd8388779;
            5'd8:    hyp_raw = 32'sd4194325;
            5'd9:    hyp_raw = 32'sd2097155;
            default: hyp_raw = 32'sh4000_0000 >>> i;
        endcase
    endfunction

    function automatic logic signed [DW-1:0] to_frac(input logic signed [31:0] raw);
        logic signed [31:0] rnd;
        rnd = (raw + (32'sd1 <<< (29 - FRAC))) >>> (30 - FRAC);
        return DW'(rnd);
    endfunction

    function automatic logic is_clip(input logic signed [DW-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [WIDTH-1:0] clip(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] c;
        if (v > SAT_HI) begin
            c = SAT_HI;
        end else if (v < SAT_LO) begin
            c = SAT_LO;
        end else begin
            c = v;
        end
        return WIDTH'(c);
    endfunction

    state_t                   state_r, state_nxt_s;
    logic signed [DW-1:0]     x_r, y_r, z_r;
    logic signed [DW-1:0]     x_nxt_s, y_nxt_s, z_nxt_s;
    logic signed [DW-1:0]     x_sh_s, y_sh_s, ang_s;
    logic [1:0]               mode_r;
    logic [IW-1:0]            idx_r;
    logic                     rep_r, rep_pt_s, last_s, d_pos_s, accept_s;
    logic                     in_ready_r, out_valid_r, sat_r;
    logic signed [WIDTH-1:0]  x_out_r, y_out_r, z_out_r;
    logic [1:0]               sel_out_r;

    assign accept_s  = in_valid && in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign x_out     = x_out_r;
    assign y_out     = y_out_r;
    assign z_out     = z_out_r;
    assign sel_out   = sel_out_r;
    assign sat       = sat_r;

    // Micro-rotation datapath and hyperbolic repeat/termination decode
    always_comb begin
        x_sh_s  = x_r >>> idx_r;
        y_sh_s  = y_r >>> idx_r;
        ang_s   = '0;
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        z_nxt_s = z_r;
        d_pos_s = (mode_r == 2'b01) ? y_r[DW-1] : !z_r[DW-1];
        case (mode_r)
            2'b00, 2'b01: ang_s = to_frac(circ_raw(idx_r));
            2'b10:        ang_s = to_frac(32'sh4000_0000 >>> idx_r);
            2'b11:        ang_s = to_frac(hyp_raw(idx_r));
            default:      ang_s = '0;
        endcase
        case (mode_r)
            2'b00, 2'b01: begin
                if (d_pos_s) begin
                    x_nxt_s = x_r - y_sh_s;
                    y_nxt_s = y_r + x_sh_s;
                    z_nxt_s = z_r - ang_s;
                end else begin
                    x_nxt_s = x_r + y_sh_s;
                    y_nxt_s = y_r - x_sh_s;
                    z_nxt_s = z_r + ang_s;
                end
            end
            2'b10: begin
                if (d_pos_s) begin
                    y_nxt_s = y_r + x_sh_s;
                    z_nxt_s = z_r - ang_s;
                end else begin
                    y_nxt_s = y_r - x_sh_s;
                    z_nxt_s = z_r + ang_s;
                end
            end
            2'b11: begin
                if (d_pos_s) begin
                    x_nxt_s = x_r + y_sh_s;
                    y_nxt_s = y_r + x_sh_s;
                    z_nxt_s = z_r - ang_s;
                end else begin
                    x_nxt_s = x_r - y_sh_s;
                    y_nxt_s = y_r - x_sh_s;
                    z_nxt_s = z_r + ang_s;
                end
            end
            default: begin
                x_nxt_s = x_r;
                y_nxt_s = y_r;
                z_nxt_s = z_r;
            end
        endcase
        rep_pt_s = (mode_r == 2'b11) && ((idx_r == 5'd4) || (idx_r == 5'd13)) && !rep_r;
        if (mode_r == 2'b11) begin
            last_s = (idx_r == LAST_HYP) && !rep_pt_s;
        end else begin
            last_s = (idx_r == LAST_LIN);
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) state_r <= IDLE;
        else              state_r <= state_nxt_s;
    end

    // Operand load, iteration and result/handshake registers
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            mode_r      <= 2'b00;
            idx_r       <= '0;
            rep_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            x_out_r     <= '0;
            y_out_r     <= '0;
            z_out_r     <= '0;
            sel_out_r   <= 2'b00;
            sat_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        x_r        <= {{GUARD{x_in[WIDTH-1]}}, x_in};
                        y_r        <= {{GUARD{y_in[WIDTH-1]}}, y_in};
                        z_r        <= {{GUARD{z_in[WIDTH-1]}}, z_in};
                        mode_r     <= sel;
                        idx_r      <= (sel == 2'b11) ? 5'd1 : 5'd0;
                        rep_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    x_r <= x_nxt_s;
                    y_r <= y_nxt_s;
                    z_r <= z_nxt_s;
                    if (rep_pt_s) begin
                        rep_r <= 1'b1;
                    end else begin
                        rep_r <= 1'b0;
                        idx_r <= idx_r + 5'd1;
                    end
                    if (last_s) begin
                        x_out_r     <= clip(x_nxt_s);
                        y_out_r     <= clip(y_nxt_s);
                        z_out_r     <= clip(z_nxt_s);
                        sel_out_r   <= mode_r;
                        sat_r       <= is_clip(x_nxt_s) || is_clip(y_nxt_s) || is_clip(z_nxt_s);
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed cases plus randomized operands
// compared against closed-form trigonometric/hyperbolic/linear reference results.
module tb_cordic_iter_engine;

    localparam int WIDTH = 16;
    localparam int FRAC  = 10;
    localparam int ITER  = 14;
    localparam int GUARD = 2;

    logic                    clk = 1'b0;
    logic                    ext_reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [1:0]              sel = 2'b00;
    logic signed [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;
    logic [1:0]              sel_out;
    logic                    sat;

    cordic_iter_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER), .GUARD(GUARD)) dut (
        .clk(clk), .ext_reset_n(ext_reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .sel_out(sel_out), .sat(sat)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  res_x, res_y, res_z, res_sel, res_sat, res_lat;
    real k_circ, k_hyp;
    int  hyp_n;
    int  hyp_seq[$];

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    function automatic int srand(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    // Issue one operation, scramble inputs after acceptance, measure latency, capture result.
    task automatic run_op(input logic [1:0] s, input int xi, input int yi, input int zi,
                          input bit release_now);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("in_ready_idle", in_ready, 1, 0);
        in_valid = 1'b1;
        sel  = s;
        x_in = WIDTH'(xi);
        y_in = WIDTH'(yi);
        z_in = WIDTH'(zi);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sel  = 2'($urandom);
        x_in = WIDTH'($urandom);
        y_in = WIDTH'($urandom);
        z_in = WIDTH'($urandom);
        res_lat = 0;
        while (!out_valid && res_lat < 100) begin
            if (res_lat == 3) check("in_ready_busy", in_ready, 0, 0);
            @(posedge clk);
            #1;
            res_lat++;
        end
        res_x = x_out; res_y = y_out; res_z = z_out;
        res_sel = sel_out; res_sat = sat;
        check("latency", res_lat, (s == 2'b11) ? hyp_n : ITER, 0);
        if (release_now) handshake();
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0, 0);
        check("x_kept", x_out, res_x, 0);
        check("in_ready_after", in_ready, 1, 0);
    endtask

    // Compare a captured result with the mathematical definition of each mode.
    task automatic check_model(input logic [1:0] s, input int xi, input int yi, input int zi);
        real xr, yr, zr, ex, ey, ez, mag;
        int  tol, tolz;
        xr = real'(xi); yr = real'(yi); zr = real'(zi) / 1024.0;
        ex = 0.0; ey = 0.0; ez = 0.0; tolz = 4;
        case (s)
            2'b00: begin
                ex = k_circ * (xr * $cos(zr) - yr * $sin(zr));
                ey = k_circ * (yr * $cos(zr) + xr * $sin(zr));
            end
            2'b01: begin
                ex = k_circ * $sqrt(xr * xr + yr * yr);
                ez = real'(zi) + $atan2(yr, xr) * 1024.0;
                tolz = 8;
            end
            2'b10: begin
                ex = xr;
                ey = yr + xr * zr;
            end
            default: begin
                ex = k_hyp * (xr * $cosh(zr) + yr * $sinh(zr));
                ey = k_hyp * (yr * $cosh(zr) + xr * $sinh(zr));
            end
        endcase
        mag = (ex < 0.0 ? -ex : ex) + (ey < 0.0 ? -ey : ey);
        tol = 16 + $rtoi(mag / 128.0);
        check("rnd_x", res_x, rnd(ex), (s == 2'b10) ? 0 : tol);
        check("rnd_y", res_y, rnd(ey), tol);
        check("rnd_z", res_z, rnd(ez), tolz);
        check("rnd_sel", res_sel, int'(s), 0);
        check("rnd_sat", res_sat, 0, 0);
    endtask

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        // Reference gains and hyperbolic index sequence from the iteration rules
        k_circ = 1.0;
        for (int i = 0; i < ITER; i++) k_circ = k_circ * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        for (int i = 1; i <= ITER; i++) begin
            hyp_seq.push_back(i);
            if (i == 4 || i == 13) hyp_seq.push_back(i);
        end
        hyp_n = hyp_seq.size();
        k_hyp = 1.0;
        foreach (hyp_seq[j]) k_hyp = k_hyp * $sqrt(1.0 - $pow(2.0, -2.0 * hyp_seq[j]));

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1, 0);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_x", x_out, 0, 0);
        check("rst_y", y_out, 0, 0);
        check("rst_z", z_out, 0, 0);
        check("rst_sel", sel_out, 0, 0);
        check("rst_sat", sat, 0, 0);
        @(negedge clk);
        ext_reset_n = 1'b1;

        run_op(2'b00, 622, 0, 536, 1'b1);
        check("t1_x", res_x, 887, 3);
        check("t1_y", res_y, 512, 3);
        check("t1_z", res_z, 0, 3);

        run_op(2'b01, 1024, 1024, 0, 1'b1);
        check("t2_x", res_x, 2385, 3);
        check("t2_y", res_y, 0, 3);
        check("t2_z", res_z, 804, 3);
        check("t2_sat", res_sat, 0, 0);

        run_op(2'b10, 512, 0, 768, 1'b1);
        check("t3_x", res_x, 512, 0);
        check("t3_y", res_y, 384, 3);
        check("t3_sel", res_sel, 2, 0);

        run_op(2'b11, 1236, 1236, 512, 1'b1);
        check("t4_x", res_x, 1688, 3);
        check("t4_y", res_y, 1688, 3);
        check("t4_lat", res_lat, 16, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] s;
            int xi, yi, zi;
            s = 2'($urandom);
            case (s)
                2'b00:   begin xi = srand(-8000, 8000); yi = srand(-8000, 8000); zi = srand(-1740, 1740); end
                2'b01:   begin xi = srand(600, 8000);   yi = srand(-8000, 8000); zi = srand(-200, 200);   end
                2'b10:   begin xi = srand(-8000, 8000); yi = srand(-8000, 8000); zi = srand(-1900, 1900); end
                default: begin xi = srand(-4000, 4000); yi = srand(-4000, 4000); zi = srand(-1024, 1024); end
            endcase
            run_op(s, xi, yi, zi, 1'b1);
            check_model(s, xi, yi, zi);
        end

        // Saturating vectoring result held while the consumer stalls
        run_op(2'b01, 32767, 32767, 0, 1'b0);
        check("t5_x", res_x, 32767, 0);
        check("t5_sat", res_sat, 1, 0);
        check("t5_sel", res_sel, 1, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sel = 2'b00; x_in = 16'sd100; y_in = 16'sd200; z_in = 16'sd300;
            @(posedge clk);
            #1;
            check("t5_hold_valid", out_valid, 1, 0);
            check("t5_hold_x", x_out, res_x, 0);
            check("t5_hold_y", y_out, res_y, 0);
            check("t5_hold_z", z_out, res_z, 0);
            check("t5_hold_sat", sat, 1, 0);
            check("t5_hold_ready", in_ready, 0, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("t5_idle_ready", in_ready, 1, 0);
            check("t5_idle_valid", out_valid, 0, 0);
        end

        // Asynchronous reset in the middle of a rotation
        @(negedge clk);
        in_valid = 1'b1;
        sel = 2'b00; x_in = 16'sd622; y_in = 16'sd0; z_in = 16'sd536;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        ext_reset_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0, 0);
        check("t6_ready", in_ready, 1, 0);
        check("t6_x", x_out, 0, 0);
        check("t6_y", y_out, 0, 0);
        check("t6_z", z_out, 0, 0);
        check("t6_sel", sel_out, 0, 0);
        check("t6_sat", sat, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        ext_reset_n = 1'b1;
        run_op(2'b00, 622, 0, 536, 1'b1);
        check("t6_lat", res_lat, 14, 0);
        check("t6_rx", res_x, 887, 3);
        check("t6_ry", res_y, 512, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
